// File: rtl/led_scanner_pkg.sv
// Shared mode and direction encodings for the LED sweep generator.
package led_scanner_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_BOUNCE    = 2'd0;
  localparam mode_t MODE_ROT_LEFT  = 2'd1;
  localparam mode_t MODE_ROT_RIGHT = 2'd2;
  localparam mode_t MODE_FILL      = 2'd3;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/led_tick_gen.sv
// Step prescaler: counts enabled cycles and fires o_step every period_reg+1 of them.
module led_tick_gen #(
  parameter int CNT_W          = 24,
  parameter int DEFAULT_PERIOD = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_period,
  output logic             o_step
);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] period_reg;

  // >= rather than == so the counter can never run past the period
  assign o_step = i_en && (cnt_reg >= period_reg);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cnt_reg    <= '0;
      period_reg <= CNT_W'(DEFAULT_PERIOD);
    end else if (i_load) begin
      period_reg <= i_period;
      cnt_reg    <= '0;
    end else if (i_en) begin
      cnt_reg <= o_step ? '0 : cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/led_scanner.sv
// LED sweep generator with four motion modes and step-aligned config updates.
// Optional LED_SCANNER_TRAIL_EN adds a 25% duty trail on the previous position.
module led_scanner
  import led_scanner_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int CNT_W          = 24,
  parameter int DEFAULT_PERIOD = 2,
  parameter int POS_W          = $clog2(WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_cfg_valid,
  output logic             o_cfg_ready,
  input  logic [1:0]       i_cfg_mode,
  input  logic [CNT_W-1:0] i_cfg_period,
  output logic [WIDTH-1:0] o_led,
  output logic [POS_W-1:0] o_pos,
  output logic             o_wrap
);

  localparam logic [POS_W-1:0] POS_LAST = POS_W'(WIDTH - 1);

  logic             step;
  logic             accept;
  logic             apply;
  logic             pending_reg, pending_next;
  mode_t            pend_mode_reg;
  logic [CNT_W-1:0] pend_period_reg;
  mode_t            mode_reg, mode_next;
  logic             dir_reg, dir_next;
  logic [POS_W-1:0] pos_reg, pos_next;
  logic             wrap_next;
  logic [WIDTH-1:0] base_next;
  logic [WIDTH-1:0] led_next;
  logic [WIDTH-1:0] led_reg;
  logic             wrap_reg;

  assign o_cfg_ready = !pending_reg;
  assign accept      = i_cfg_valid && !pending_reg;
  // While paused there is no step to wait for, so apply straight away
  assign apply       = pending_reg && (step || !i_en);

  led_tick_gen #(
    .CNT_W          (CNT_W),
    .DEFAULT_PERIOD (DEFAULT_PERIOD)
  ) u_tick (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_en     (i_en),
    .i_load   (apply),
    .i_period (pend_period_reg),
    .o_step   (step)
  );

  always_comb begin
    pos_next     = pos_reg;
    dir_next     = dir_reg;
    mode_next    = mode_reg;
    pending_next = pending_reg;
    wrap_next    = 1'b0;
    if (step) begin
      case (mode_reg)
        MODE_BOUNCE: begin
          if (dir_reg == DIR_UP) begin
            if (pos_reg == POS_LAST) begin
              pos_next = POS_LAST - POS_W'(1);
              dir_next = DIR_DOWN;
            end else begin
              pos_next = pos_reg + POS_W'(1);
            end
          end else begin
            if (pos_reg == '0) begin
              pos_next = POS_W'(1);
              dir_next = DIR_UP;
            end else begin
              pos_next = pos_reg - POS_W'(1);
            end
          end
        end
        MODE_ROT_RIGHT: pos_next = (pos_reg == '0) ? POS_LAST : pos_reg - POS_W'(1);
        default:        pos_next = (pos_reg == POS_LAST) ? '0 : pos_reg + POS_W'(1);
      endcase
      wrap_next = (mode_reg == MODE_ROT_RIGHT) ? (pos_next == POS_LAST) : (pos_next == '0);
    end
    // The motion above used the old mode; the new one takes over from here
    if (apply) begin
      mode_next    = pend_mode_reg;
      dir_next     = (pend_mode_reg == MODE_ROT_RIGHT) ? DIR_DOWN : DIR_UP;
      pending_next = 1'b0;
    end
    if (accept) pending_next = 1'b1;
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_base
    assign base_next[gi] = (mode_next == MODE_FILL) ? (POS_W'(gi) <= pos_next)
                                                    : (POS_W'(gi) == pos_next);
  end

`ifdef LED_SCANNER_TRAIL_EN
  logic [1:0]       pwm_reg;
  logic [POS_W-1:0] prev_reg, prev_next;
  logic             trail_reg, trail_next;
  logic [WIDTH-1:0] trail_mask;

  always_comb begin
    prev_next  = prev_reg;
    trail_next = trail_reg;
    if (step) begin
      prev_next  = pos_reg;
      trail_next = 1'b1;
    end
    if (apply && (pend_mode_reg != mode_reg)) trail_next = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      pwm_reg   <= '0;
      prev_reg  <= '0;
      trail_reg <= 1'b0;
    end else begin
      pwm_reg   <= pwm_reg + 2'd1;
      prev_reg  <= prev_next;
      trail_reg <= trail_next;
    end
  end

  // The trail is lit in the cycle where pwm_reg reads 0
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_trail
    assign trail_mask[gi] = trail_next && (pwm_reg == 2'd3) && (mode_next != MODE_FILL)
                            && (POS_W'(gi) == prev_next);
  end

  assign led_next = base_next | trail_mask;
`else
  assign led_next = base_next;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      pos_reg         <= '0;
      dir_reg         <= DIR_UP;
      mode_reg        <= MODE_BOUNCE;
      pending_reg     <= 1'b0;
      pend_mode_reg   <= MODE_BOUNCE;
      pend_period_reg <= '0;
      led_reg         <= WIDTH'(1);
      wrap_reg        <= 1'b0;
    end else begin
      pos_reg     <= pos_next;
      dir_reg     <= dir_next;
      mode_reg    <= mode_next;
      pending_reg <= pending_next;
      led_reg     <= led_next;
      wrap_reg    <= wrap_next;
      if (accept) begin
        pend_mode_reg   <= i_cfg_mode;
        pend_period_reg <= i_cfg_period;
      end
    end
  end

  assign o_led  = led_reg;
  assign o_pos  = pos_reg;
  assign o_wrap = wrap_reg;

endmodule

// File: tb/tb_led_scanner.sv
// Directed bench for led_scanner: an 8-LED instance and a 5-LED instance on one clock.
module tb_led_scanner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n_a = 1'b0, en_a = 1'b0, valid_a = 1'b0;
  logic [1:0]  mode_a = 2'd0;
  logic [23:0] period_a = '0;
  logic        ready_a, wrap_a;
  logic [7:0]  led_a;
  logic [2:0]  pos_a;

  logic        rst_n_b = 1'b0, en_b = 1'b0, valid_b = 1'b0;
  logic [1:0]  mode_b = 2'd0;
  logic [23:0] period_b = '0;
  logic        ready_b, wrap_b;
  logic [4:0]  led_b;
  logic [2:0]  pos_b;

  int checks = 0;
  int errors = 0;

  led_scanner #(.WIDTH(8)) dut_a (
    .i_clk        (clk),
    .i_rst_n      (rst_n_a),
    .i_en         (en_a),
    .i_cfg_valid  (valid_a),
    .o_cfg_ready  (ready_a),
    .i_cfg_mode   (mode_a),
    .i_cfg_period (period_a),
    .o_led        (led_a),
    .o_pos        (pos_a),
    .o_wrap       (wrap_a)
  );

  led_scanner #(.WIDTH(5)) dut_b (
    .i_clk        (clk),
    .i_rst_n      (rst_n_b),
    .i_en         (en_b),
    .i_cfg_valid  (valid_b),
    .o_cfg_ready  (ready_b),
    .i_cfg_mode   (mode_b),
    .i_cfg_period (period_b),
    .o_led        (led_b),
    .o_pos        (pos_b),
    .o_wrap       (wrap_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s got=%0h", tag, got);
    end
  endtask

  task automatic edges(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  int bounce_seq [14] = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0};
  int fill_seq   [5]  = '{'h03, 'h07, 'h0f, 'h1f, 'h01};

  initial begin
    int wraps;
    int prev;

    edges(2);
    check_eq("rst_led", 32'(led_a), 32'h01);
    check_eq("rst_pos", 32'(pos_a), 32'd0);
    check_eq("rst_wrap", 32'(wrap_a), 32'd0);
    check_eq("rst_ready", 32'(ready_a), 32'd1);

    // Bounce sweep, default period 2: one step every third edge
    rst_n_a = 1'b1;
    en_a    = 1'b1;
    wraps   = 0;
    prev    = 0;
    for (int i = 0; i < 14; i++) begin
      edges(1);
      wraps += int'(wrap_a);
      edges(1);
      wraps += int'(wrap_a);
      check_eq("bounce_hold", 32'(pos_a), 32'(prev));
      edges(1);
      wraps += int'(wrap_a);
      check_eq("bounce_pos", 32'(pos_a), 32'(bounce_seq[i]));
      check_eq("bounce_led", 32'(led_a), 32'd1 << bounce_seq[i]);
      check_eq("bounce_wrap", 32'(wrap_a), (bounce_seq[i] == 0) ? 32'd1 : 32'd0);
      prev = bounce_seq[i];
    end
    check_eq("bounce_wrap_count", 32'(wraps), 32'd1);

    // Pause at pos 3 with one count already banked
    edges(9);
    check_eq("pause_pos", 32'(pos_a), 32'd3);
    edges(1);
    en_a = 1'b0;
    for (int i = 0; i < 10; i++) begin
      edges(1);
      check_eq("pause_led", 32'(led_a), 32'h08);
    end
    en_a = 1'b1;
    edges(1);
    check_eq("resume_hold", 32'(pos_a), 32'd3);
    edges(1);
    check_eq("resume_pos", 32'(pos_a), 32'd4);
    check_eq("resume_led", 32'(led_a), 32'h10);

    // Back-to-back offers: ROT_LEFT period 0 then FILL period 5
    valid_a  = 1'b1;
    mode_a   = 2'd1;
    period_a = 24'd0;
    edges(1);
    check_eq("hs_ready_low", 32'(ready_a), 32'd0);
    mode_a   = 2'd3;
    period_a = 24'd5;
    edges(1);
    check_eq("hs_stall", 32'(ready_a), 32'd0);
    check_eq("hs_stall_pos", 32'(pos_a), 32'd4);
    edges(1);
    check_eq("hs_apply_pos", 32'(pos_a), 32'd5);
    check_eq("hs_apply_led", 32'(led_a), 32'h20);
    check_eq("hs_apply_ready", 32'(ready_a), 32'd1);
    edges(1);
    check_eq("hs_rotl_pos", 32'(pos_a), 32'd6);
    check_eq("hs_second_ready", 32'(ready_a), 32'd0);

    // Reset with the second offer still pending
    valid_a = 1'b0;
    rst_n_a = 1'b0;
    edges(1);
    check_eq("mid_rst_led", 32'(led_a), 32'h01);
    check_eq("mid_rst_pos", 32'(pos_a), 32'd0);
    check_eq("mid_rst_wrap", 32'(wrap_a), 32'd0);
    check_eq("mid_rst_ready", 32'(ready_a), 32'd1);
    rst_n_a = 1'b1;
    edges(3);
    check_eq("post_rst_pos", 32'(pos_a), 32'd1);
    check_eq("post_rst_led", 32'(led_a), 32'h02);
    check_eq("post_rst_ready", 32'(ready_a), 32'd1);

    // ROT_RIGHT configured while paused, straight after reset
    rst_n_a = 1'b0;
    en_a    = 1'b0;
    edges(1);
    rst_n_a  = 1'b1;
    valid_a  = 1'b1;
    mode_a   = 2'd2;
    period_a = 24'd2;
    edges(1);
    check_eq("rr_ready_low", 32'(ready_a), 32'd0);
    valid_a = 1'b0;
    edges(1);
    check_eq("rr_ready_back", 32'(ready_a), 32'd1);
    check_eq("rr_led0", 32'(led_a), 32'h01);
    en_a = 1'b1;
    edges(2);
    check_eq("rr_hold", 32'(pos_a), 32'd0);
    edges(1);
    check_eq("rr_pos7", 32'(pos_a), 32'd7);
    check_eq("rr_wrap7", 32'(wrap_a), 32'd1);
    check_eq("rr_led7", 32'(led_a), 32'h80);
    edges(1);
    check_eq("rr_wrap_pulse", 32'(wrap_a), 32'd0);
    edges(2);
    check_eq("rr_pos6", 32'(pos_a), 32'd6);
    check_eq("rr_led6", 32'(led_a), 32'h40);

`ifdef LED_SCANNER_TRAIL_EN
    begin
      int n18;
      int n10;
      rst_n_a = 1'b0;
      en_a    = 1'b0;
      edges(1);
      rst_n_a  = 1'b1;
      valid_a  = 1'b1;
      mode_a   = 2'd1;
      period_a = 24'd0;
      edges(1);
      valid_a = 1'b0;
      edges(1);
      en_a = 1'b1;
      edges(4);
      check_eq("trail_pos", 32'(pos_a), 32'd4);
      en_a = 1'b0;
      n18  = 0;
      n10  = 0;
      for (int i = 0; i < 8; i++) begin
        edges(1);
        if (led_a == 8'h18) n18++;
        if (led_a == 8'h10) n10++;
      end
      check_eq("trail_on", 32'(n18), 32'd2);
      check_eq("trail_off", 32'(n10), 32'd6);
    end
`endif

    // Five-LED FILL at period 0: one step per cycle
    rst_n_b  = 1'b1;
    valid_b  = 1'b1;
    mode_b   = 2'd3;
    period_b = 24'd0;
    edges(1);
    valid_b = 1'b0;
    edges(1);
    check_eq("fill_led0", 32'(led_b), 32'h01);
    check_eq("fill_ready", 32'(ready_b), 32'd1);
    en_b = 1'b1;
    for (int i = 0; i < 5; i++) begin
      edges(1);
      check_eq("fill_led", 32'(led_b), 32'(fill_seq[i]));
      check_eq("fill_pos", 32'(pos_b), 32'((i + 1) % 5));
      check_eq("fill_wrap", 32'(wrap_b), (i == 4) ? 32'd1 : 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
